// File: rtl/sonar_pkg.sv
// Shared sonar constants, sample type and the steering-delay function.
// The transmit beamformer uses the same function, so TX and RX steering stay consistent.
package sonar_pkg;

    localparam int NUM_RECEIVERS   = 4;
    localparam int ELEMENT_SPACING = 9;        // mm
    localparam int SPEED_OF_SOUND  = 343000;   // mm/s
    localparam int SAMPLE_RATE     = 1000000;  // Hz
    localparam int SIN_WIDTH       = 16;
    localparam int SAMPLE_WIDTH    = 12;
    localparam int MAX_DELAY       = 128;

    // Inter-element delay in samples for sin_theta == 1.0.
    localparam int DELAY_CONST = (ELEMENT_SPACING * SAMPLE_RATE) / SPEED_OF_SOUND;
    localparam int PTR_W       = $clog2(MAX_DELAY);
    localparam int FILL_W      = PTR_W + 1;
    localparam int SUM_W       = SAMPLE_WIDTH + $clog2(NUM_RECEIVERS);

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [PTR_W-1:0]               delay_t;

    function automatic delay_t calc_delay(input int unsigned i,
                                          input logic [SIN_WIDTH-1:0] sin_theta,
                                          input logic sign_bit);
        logic [63:0] weight;
        logic [63:0] prod;
        weight = sign_bit ? 64'(i) : 64'(NUM_RECEIVERS - 1 - int'(i));
        prod   = (64'(DELAY_CONST) * weight * 64'(sin_theta)) >> (SIN_WIDTH - 1);
        if (prod > 64'(MAX_DELAY - 1)) begin
            return delay_t'(MAX_DELAY - 1);
        end
        return prod[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/receive_beamformer_delay_line.sv
// One channel's circular delay line: simple dual-port RAM with registered read.
// A zero delay bypasses the RAM, so the read never collides with the same-address write.
module delay_line
    import sonar_pkg::*;
(
    input  logic                    clk,
    input  logic                    we,
    input  logic [PTR_W-1:0]        wr_ptr,
    input  logic [PTR_W-1:0]        delay,
    input  logic [SAMPLE_WIDTH-1:0] din,
    output logic [SAMPLE_WIDTH-1:0] dout
);

    logic [SAMPLE_WIDTH-1:0] mem [MAX_DELAY];
    logic [PTR_W-1:0]        rd_addr;

    assign rd_addr = wr_ptr - delay;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            dout <= (delay == '0) ? din : mem[rd_addr];
        end
    end

endmodule

// File: rtl/receive_beamformer.sv
// Receive delay-and-sum beamformer: per-channel steered delay lines feeding a registered adder.
// sample_valid_in is a push with no backpressure; sum_valid_out is a one-cycle strobe, two cycles later.
module receive_beamformer
    import sonar_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      rst_in,
    input  logic [SIN_WIDTH-1:0]                      sin_theta,
    input  logic                                      sign_bit,
    input  logic                                      steer_load,
    input  logic                                      sample_valid_in,
    input  logic [NUM_RECEIVERS-1:0][SAMPLE_WIDTH-1:0] samples_in,
    output logic [SUM_W-1:0]                          sum_out,
    output logic                                      sum_valid_out
);

    logic [PTR_W-1:0]                          wr_ptr;
    logic [FILL_W-1:0]                         fill_cnt;
    logic [PTR_W-1:0]                          delay_q [NUM_RECEIVERS];
    logic [NUM_RECEIVERS-1:0][SAMPLE_WIDTH-1:0] tap;
    logic                                      rd_valid;
    logic [SUM_W-1:0]                          sum_comb;
    logic                                      warm;

    assign warm = (fill_cnt == FILL_W'(MAX_DELAY));

    for (genvar g = 0; g < NUM_RECEIVERS; g++) begin : g_line
        delay_line u_line (
            .clk    (clk),
            .we     (sample_valid_in),
            .wr_ptr (wr_ptr),
            .delay  (delay_q[g]),
            .din    (samples_in[g]),
            .dout   (tap[g])
        );
    end

    always_comb begin
        sum_comb = '0;
        for (int i = 0; i < NUM_RECEIVERS; i++) begin
            sum_comb = sum_comb + {{(SUM_W-SAMPLE_WIDTH){tap[i][SAMPLE_WIDTH-1]}}, tap[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            wr_ptr        <= '0;
            fill_cnt      <= '0;
            rd_valid      <= 1'b0;
            sum_out       <= '0;
            sum_valid_out <= 1'b0;
            for (int i = 0; i < NUM_RECEIVERS; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            // New delays take effect from the next sample; a sample arriving with steer_load uses the old ones.
            if (steer_load) begin
                for (int i = 0; i < NUM_RECEIVERS; i++) begin
                    delay_q[i] <= calc_delay(i, sin_theta, sign_bit);
                end
            end
            if (sample_valid_in) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (!warm) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
            rd_valid      <= sample_valid_in && warm;
            sum_valid_out <= rd_valid;
            if (rd_valid) begin
                sum_out <= sum_comb;
            end
        end
    end

endmodule

// File: tb/tb_receive_beamformer.sv
// Directed bench for receive_beamformer: hand-computed steering delays, warm-up, impulses, coherent sum, reset.
module tb_receive_beamformer;

    logic                     clk;
    logic                     rst_in;
    logic [15:0]              sin_theta;
    logic                     sign_bit;
    logic                     steer_load;
    logic                     sample_valid_in;
    logic [3:0][11:0]         samples_in;
    logic signed [13:0]       sum_out;
    logic                     sum_valid_out;

    receive_beamformer dut (
        .clk             (clk),
        .rst_in          (rst_in),
        .sin_theta       (sin_theta),
        .sign_bit        (sign_bit),
        .steer_load      (steer_load),
        .sample_valid_in (sample_valid_in),
        .samples_in      (samples_in),
        .sum_out         (sum_out),
        .sum_valid_out   (sum_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: sample history per channel, indexed by sample number since reset.
    logic signed [11:0] hist [4][2048];
    logic signed [13:0] got  [2048];
    int                 dly  [4];
    int                 n;
    logic               pend_v;
    logic signed [13:0] pend_sum;
    int                 pend_idx;
    logic signed [13:0] exp_sum;
    int                 strobe_cnt;
    int                 first_idx;
    logic [15:0]        cur_sin;
    logic               cur_sb;
    int                 k;
    int                 ka;

    task automatic chk(input string tag, input logic signed [31:0] g, input logic signed [31:0] w);
        total++;
        assert (g === w) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, g, w);
        end
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    // One clock: drive inputs, then check the outputs owed by the previous cycle's sample.
    task automatic cyc(input logic v, input logic signed [11:0] s0, input logic signed [11:0] s1,
                       input logic signed [11:0] s2, input logic signed [11:0] s3, input logic ld);
        logic               nv;
        logic signed [13:0] ns;
        logic [11:0]        h;
        int                 ni;
        sample_valid_in = v;
        samples_in[0] = s0; samples_in[1] = s1; samples_in[2] = s2; samples_in[3] = s3;
        steer_load = ld;
        sin_theta  = cur_sin;
        sign_bit   = cur_sb;
        nv = 1'b0;
        ns = '0;
        ni = n;
        if (v) begin
            hist[0][n] = s0; hist[1][n] = s1; hist[2][n] = s2; hist[3][n] = s3;
            if (n >= 128) begin
                nv = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    h  = hist[c][n - dly[c]];
                    ns = ns + {{2{h[11]}}, h};
                end
            end
            n++;
        end
        @(posedge clk);
        #1;
        sample_valid_in = 1'b0;
        steer_load      = 1'b0;
        if (pend_v) exp_sum = pend_sum;
        chk("cyc_valid", sum_valid_out, pend_v);
        chk("cyc_sum", sum_out, exp_sum);
        if (sum_valid_out) begin
            strobe_cnt++;
            if (pend_v) got[pend_idx] = sum_out;
            if (first_idx < 0) first_idx = pend_idx;
        end
        pend_v   = nv;
        pend_sum = ns;
        pend_idx = ni;
    endtask

    task automatic send(input logic signed [11:0] s0, input logic signed [11:0] s1,
                        input logic signed [11:0] s2, input logic signed [11:0] s3);
        cyc(1'b1, s0, s1, s2, s3, 1'b0);
    endtask

    task automatic idle(input int cycles);
        for (int j = 0; j < cycles; j++) cyc(1'b0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 1'b0);
    endtask

    task automatic steer(input logic [15:0] s, input logic b);
        cur_sin = s;
        cur_sb  = b;
        cyc(1'b0, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 1'b1);
    endtask

    task automatic do_reset();
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        steer_load      = 1'b0;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        chk("rst_valid", sum_valid_out, 1'b0);
        chk("rst_sum", sum_out, 0);
        n = 0; pend_v = 1'b0; pend_sum = '0; pend_idx = 0; exp_sum = '0;
        strobe_cnt = 0; first_idx = -1;
        set_dly(0, 0, 0, 0);
    endtask

    initial begin
        rst_in = 1'b1; sample_valid_in = 1'b0; steer_load = 1'b0;
        sin_theta = '0; sign_bit = 1'b0; samples_in = '0;
        cur_sin = '0; cur_sb = 1'b0;
        @(posedge clk);
        do_reset();

        // Warm-up: 128 silent samples, then the first strobe belongs to sample 128.
        steer(16'h4000, 1'b0);
        set_dly(39, 26, 13, 0);
        repeat (128) send(0, 0, 0, 0);
        chk("warm_no_strobe", strobe_cnt, 0);
        send(0, 0, 0, 0);
        chk("warm_t+1_quiet", sum_valid_out, 1'b0);
        idle(1);
        chk("warm_t+2_strobe", sum_valid_out, 1'b1);
        idle(1);
        chk("first_strobe_idx", first_idx, 128);
        chk("strobe_cnt", strobe_cnt, 1);

        // Impulse on the broadside-most element (delay 0), then on ch0 (delay 39).
        k = n;
        send(0, 0, 0, 100);
        repeat (45) send(0, 0, 0, 0);
        idle(2);
        chk("imp_ch3_k", got[k], 100);
        chk("imp_ch3_k+1", got[k+1], 0);
        k = n;
        send(100, 0, 0, 0);
        repeat (45) send(0, 0, 0, 0);
        idle(2);
        chk("imp_ch0_k", got[k], 0);
        chk("imp_ch0_k+38", got[k+38], 0);
        chk("imp_ch0_k+39", got[k+39], 100);

        // Coherent arrival across the array adds up in a single output sample.
        k = n;
        for (int j = 0; j < 46; j++)
            send(j == 0 ? 12'sd100 : 12'sd0, j == 13 ? 12'sd100 : 12'sd0,
                 j == 26 ? 12'sd100 : 12'sd0, j == 39 ? 12'sd100 : 12'sd0);
        idle(2);
        chk("coh_k+38", got[k+38], 0);
        chk("coh_k+39", got[k+39], 400);
        chk("coh_k+40", got[k+40], 0);

        // Opposite side, near-unity sine: delays 0,25,51,77; full-scale negative input.
        steer(16'h7FFF, 1'b1);
        set_dly(0, 25, 51, 77);
        k = n;
        repeat (80) send(-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048);
        idle(2);
        chk("fs_partial_k+40", got[k+40], -4096);
        chk("fs_full_k+79", got[k+79], -8192);

        // sin_theta all ones: delays 0,51,103 and ch3 saturated at 127.
        steer(16'hFFFF, 1'b1);
        set_dly(0, 51, 103, 127);
        k = n;
        repeat (130) send(-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048);
        idle(2);
        chk("sat_fs_k+129", got[k+129], -8192);
        repeat (130) send(0, 0, 0, 0);
        k = n;
        send(0, 0, 0, 100);
        repeat (130) send(0, 0, 0, 0);
        idle(2);
        chk("sat_imp_k+27", got[k+27], 0);
        chk("sat_imp_k+127", got[k+127], 100);

        // steer_load with a sample: that sample uses old delays (ch1=51), the next uses new (ch1=26).
        for (int j = 0; j < 60; j++)
            send(0, j == 9 ? 12'sd7 : (j == 35 ? 12'sd9 : 12'sd0), 0, 0);
        ka = n;
        cur_sin = 16'h4000;
        cur_sb  = 1'b0;
        cyc(1'b1, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 1'b1);
        set_dly(39, 26, 13, 0);
        send(0, 0, 0, 0);
        idle(2);
        chk("ld_same_cycle_old", got[ka], 7);
        chk("ld_next_new", got[ka+1], 9);

        // Mid-stream reset drops the in-flight strobe and restarts warm-up.
        send(5, 5, 5, 5);
        do_reset();
        idle(1);
        chk("rst_inflight_dropped", sum_valid_out, 1'b0);
        repeat (128) send(5, 5, 5, 5);
        idle(2);
        chk("rewarm_no_strobe", strobe_cnt, 0);
        send(5, 5, 5, 5);
        idle(2);
        chk("rewarm_sum", got[128], 20);
        chk("rewarm_first_idx", first_idx, 128);
        chk("rewarm_strobe_cnt", strobe_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
